// File: rtl/instr_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Instruction store with a run-time program-load port and an
//                autonomous sequential prefetcher feeding a FIFO_DEPTH-entry
//                queue.  Presents {instr, pc, oob} to decode over valid/ready
//                and supports branch redirect with full flush.
//
//  Ports       : clk, rst_n               clock, async active-low reset
//                redirect_valid/_pc       flush and restart fetch
//                out_valid/_ready         decode handshake
//                out_instr/_pc/_oob       head entry fields
//                prog_we/_addr/_data      program-load write port
//                fetch_pc                 current fetch PC (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int FIFO_DEPTH  = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   out_oob,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [ADDR_WIDTH-1:0]  fetch_pc
);

    localparam int                  c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int                  c_cnt_w      = c_ptr_w + 1;
    localparam int                  c_mem_aw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_depth_ext  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_fifo_depth = c_cnt_w'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);

    // ------------------------------------------------------------------
    // Instruction store (not reset)
    // ------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [INSTR_WIDTH-1:0] rdata_q,    rdata_d;
    logic [ADDR_WIDTH-1:0]  pc_q,       pc_d;
    logic                   oob_q,      oob_d;
    logic [c_cnt_w-1:0]     count_q,    count_d;
    logic [c_ptr_w-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q,   rd_ptr_d;

    logic [INSTR_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] fifo_instr_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_d    [FIFO_DEPTH];
    logic                   fifo_oob_q   [FIFO_DEPTH];
    logic                   fifo_oob_d   [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    logic                 w_fetch_oob;
    logic                 w_prog_hit;
    logic [c_cnt_w-1:0]   w_credit;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [c_mem_aw-1:0]  w_rd_idx;
    logic [c_mem_aw-1:0]  w_wr_idx;

    assign w_fetch_oob = ({1'b0, fetch_pc_q} >= c_depth_ext);
    assign w_prog_hit  = prog_we && ({1'b0, prog_addr} < c_depth_ext);
    assign w_rd_idx    = fetch_pc_q[c_mem_aw-1:0];
    assign w_wr_idx    = prog_addr[c_mem_aw-1:0];

    // Credit counts the in-flight read as occupied; a same-edge pop is
    // deliberately not credited so the push slot is always guaranteed.
    assign w_credit    = count_q + {{(c_cnt_w-1){1'b0}}, inflight_q};
    assign w_issue     = !redirect_valid && (w_credit < c_fifo_depth);
    assign w_push      = inflight_q && !redirect_valid;
    assign w_pop       = out_valid && out_ready && !redirect_valid;

    assign out_valid   = (count_q != '0);
    assign out_instr   = fifo_instr_q[rd_ptr_q];
    assign out_pc      = fifo_pc_q[rd_ptr_q];
    assign out_oob     = fifo_oob_q[rd_ptr_q];
    assign fetch_pc    = fetch_pc_q;

    // Write port only; the read is captured into rdata_q, and because the
    // capture uses the pre-edge array contents the port behaves read-first.
    always_ff @(posedge clk) begin
        if (w_prog_hit) begin
            mem[w_wr_idx] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = inflight_q;
        rdata_d      = rdata_q;
        pc_d         = pc_q;
        oob_d        = oob_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_oob_d   = fifo_oob_q;

        if (redirect_valid) begin
            // Redirect drops the queue, the in-flight read and any handshake.
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            inflight_d = w_issue;
            if (w_issue) begin
                rdata_d    = w_fetch_oob ? '0 : mem[w_rd_idx];
                pc_d       = fetch_pc_q;
                oob_d      = w_fetch_oob;
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end

            if (w_push) begin
                fifo_instr_d[wr_ptr_q] = rdata_q;
                fifo_pc_d[wr_ptr_q]    = pc_q;
                fifo_oob_d[wr_ptr_q]   = oob_q;
                wr_ptr_d               = wr_ptr_q + c_ptr_w'(1);
            end

            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end

            if (w_push && !w_pop) begin
                count_d = count_q + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - c_cnt_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= c_reset_pc;
            inflight_q   <= 1'b0;
            rdata_q      <= '0;
            pc_q         <= '0;
            oob_q        <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
            fifo_oob_q   <= '{default: 1'b0};
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            rdata_q      <= rdata_d;
            pc_q         <= pc_d;
            oob_q        <= oob_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_oob_q   <= fifo_oob_d;
        end
    end

endmodule
`default_nettype wire
